// File: rtl/dsp12_sched_pkg.sv
// Shared types and constants for the DSP12 job scheduler.
// No logic: FSM state encoding, DSP opcode and the DSP12 configuration.
// No flow control.
package dsp12_sched_pkg;

   // Scheduler FSM states
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CLEAR = 3'd1,
      ST_LOAD  = 3'd2,
      ST_ACCUM = 3'd3,
      ST_DRAIN = 3'd4,
      ST_RESP  = 3'd5
   } state_e;

   // DSP12 add/sub opcode: plain add
   localparam logic [1:0] DSP_OP_ADD = 2'b00;

   // DSP12 operand source selects
   typedef enum logic [1:0] {
      DSP_SRC_X = 2'd0,
      DSP_SRC_W = 2'd1,
      DSP_SRC_P = 2'd2
   } dsp_src_e;

   // DSP12 strapping: signed MAC, W <= A*B + W on each CE edge,
   // output register enabled so DSP_O lags W by one CE edge.
   localparam bit       DSP12_SIGNED = 1'b1;
   localparam dsp_src_e DSP12_M_SEL  = DSP_SRC_P;
   localparam dsp_src_e DSP12_N_SEL  = DSP_SRC_W;
   localparam dsp_src_e DSP12_W_SEL  = DSP_SRC_X;
   localparam bit       DSP12_A_REG  = 1'b0;
   localparam bit       DSP12_B_REG  = 1'b0;
   localparam bit       DSP12_C_REG  = 1'b0;
   localparam bit       DSP12_P_REG  = 1'b0;
   localparam bit       DSP12_W_REG  = 1'b1;
   localparam bit       DSP12_O_REG  = 1'b1;

endpackage

// File: rtl/dsp12_rr_arb.sv
// Round-robin arbiter: one-hot grant, pointer moves one past the winner.
// Latency: grant is combinational from req; pointer updates on advance edge.
// No backpressure: caller holds req until it consumes the grant.
module dsp12_rr_arb #(
   parameter int NREQ = 2
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [NREQ-1:0] req,
   input  logic            advance,
   output logic [NREQ-1:0] gnt
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]     ptr_q;
   logic [2*NREQ-1:0] req_dbl;
   logic [NREQ-1:0]   req_rot;
   logic              found;
   logic [PW-1:0]     win_idx;

   // Search requests starting at the pointer; first hit wins
   always_comb begin
      req_dbl = {req, req} >> ptr_q;
      req_rot = req_dbl[NREQ-1:0];
      gnt     = '0;
      found   = 1'b0;
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && req_rot[i]) begin
            found   = 1'b1;
            win_idx = PW'((i + int'(ptr_q)) % NREQ);
         end
      end
      if (found) gnt[win_idx] = 1'b1;
   end

   // Pointer moves to one past the winner when the grant is taken
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ptr_q <= '0;
      end else if (advance && found) begin
         ptr_q <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
      end
   end

endmodule

// File: rtl/dsp12_sched.sv
// DSP12 MAC job scheduler: arbitrates requesters, streams operand pairs into the DSP12.
// Latency: START to RES_VALID = LEN+4 cycles with operands always valid.
// Backpressure: OPND_VALID stalls accumulation; RESP holds until RES_READY. Optional watchdog: DSP12_SCHED_TIMEOUT_EN.
module dsp12_sched
   import dsp12_sched_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int LEN_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [NREQ-1:0]       START,
   input  logic [NREQ*LEN_W-1:0] LEN,
   input  logic [NREQ*4-1:0]     SHIFT,
   output logic [NREQ-1:0]       GNT,
   output logic                  BUSY,
   input  logic                  OPND_VALID,
   output logic                  OPND_READY,
   input  logic [3:0]            OPND_A,
   input  logic [3:0]            OPND_B,
   output logic                  RES_VALID,
   input  logic                  RES_READY,
   output logic [11:0]           RES_DATA,
   output logic                  RES_ERR,
   output logic [3:0]            DSP_A,
   output logic [3:0]            DSP_B,
   output logic [3:0]            DSP_C,
   output logic [1:0]            DSP_OP,
   output logic                  DSP_CE,
   output logic                  DSP_RST,
   output logic                  DSP_SHIFT_ENA,
   input  logic [11:0]           DSP_O
);

   state_e            state_q, state_d;
   logic [NREQ-1:0]   gnt_q;
   logic [LEN_W-1:0]  len_q;
   logic [3:0]        shift_q;
   logic [LEN_W-1:0]  beat_q;
   logic [NREQ-1:0]   arb_gnt;
   logic              arb_adv;
   logic [LEN_W-1:0]  sel_len;
   logic [3:0]        sel_shift;
   logic              last_beat;
   logic              rsp_err;
   logic              idle_expire;

   assign arb_adv   = (state_q == ST_IDLE) && (|START);
   assign last_beat = OPND_VALID && (beat_q == len_q - LEN_W'(1));

   dsp12_rr_arb #(.NREQ(NREQ)) u_arb (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .req     (START),
      .advance (arb_adv),
      .gnt     (arb_gnt)
   );

   // Pick the winner's job descriptor out of the flat request buses
   always_comb begin
      sel_len   = '0;
      sel_shift = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_gnt[i]) begin
            sel_len   = LEN[i*LEN_W +: LEN_W];
            sel_shift = SHIFT[i*4 +: 4];
         end
      end
   end

`ifdef DSP12_SCHED_TIMEOUT_EN
   localparam int IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [IDLE_W-1:0] idle_q;
   logic              err_q;

   assign idle_expire = !OPND_VALID && (idle_q == IDLE_W'(TIMEOUT - 1));
   assign rsp_err     = err_q;

   // Watchdog: count starved ACCUM cycles, flag an abort when it expires
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         idle_q <= '0;
         err_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               idle_q <= '0;
               err_q  <= 1'b0;
            end
            ST_ACCUM: begin
               if (OPND_VALID)       idle_q <= '0;
               else if (idle_expire) err_q  <= 1'b1;
               else                  idle_q <= idle_q + IDLE_W'(1);
            end
            default: ;
         endcase
      end
   end
`else
   // TIMEOUT only matters when the watchdog is built in
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign idle_expire    = 1'b0;
   assign rsp_err        = 1'b0;
`endif

   assign RES_ERR = (state_q == ST_RESP) && rsp_err;
   assign GNT     = gnt_q;
   assign BUSY    = (state_q != ST_IDLE);
   assign DSP_OP  = DSP_OP_ADD;

   // Next state and per-state DSP/handshake controls
   always_comb begin
      state_d       = state_q;
      OPND_READY    = 1'b0;
      RES_VALID     = 1'b0;
      RES_DATA      = '0;
      DSP_A         = '0;
      DSP_B         = '0;
      DSP_C         = '0;
      DSP_CE        = 1'b0;
      DSP_RST       = 1'b0;
      DSP_SHIFT_ENA = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|START) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            DSP_RST = 1'b1;
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            DSP_SHIFT_ENA = 1'b1;
            DSP_C         = shift_q;
            state_d       = (len_q == '0) ? ST_DRAIN : ST_ACCUM;
         end
         ST_ACCUM: begin
            OPND_READY = 1'b1;
            DSP_CE     = OPND_VALID;
            DSP_A      = OPND_A;
            DSP_B      = OPND_B;
            if (last_beat)        state_d = ST_DRAIN;
            else if (idle_expire) state_d = ST_RESP;
         end
         ST_DRAIN: begin
            // Zero product pass moves the finished W through the shifter into O
            DSP_CE  = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            RES_VALID = 1'b1;
            RES_DATA  = rsp_err ? 12'h000 : DSP_O;
            if (RES_READY) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register, job descriptor latch, grant and beat counting
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         gnt_q   <= '0;
         len_q   <= '0;
         shift_q <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (|START) begin
                  gnt_q   <= arb_gnt;
                  len_q   <= sel_len;
                  shift_q <= sel_shift;
                  beat_q  <= '0;
               end
            end
            ST_ACCUM: begin
               if (OPND_VALID) beat_q <= beat_q + LEN_W'(1);
            end
            ST_RESP: begin
               if (RES_READY) gnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dsp12_sched.sv
// Bench for dsp12_sched with a behavioural DSP12 attached to the DSP_* pins.
// Jobs are scored against a sum-of-products / shift model and a round-robin model.
// Random operand gaps and result stalls exercise both handshakes.
module tb_dsp12_sched;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [1:0]  START;
   logic [15:0] LEN;
   logic [7:0]  SHIFT;
   logic [1:0]  GNT;
   logic        BUSY;
   logic        OPND_VALID;
   logic        OPND_READY;
   logic [3:0]  OPND_A, OPND_B;
   logic        RES_VALID;
   logic        RES_READY;
   logic [11:0] RES_DATA;
   logic        RES_ERR;
   logic [3:0]  DSP_A, DSP_B, DSP_C;
   logic [1:0]  DSP_OP;
   logic        DSP_CE, DSP_RST, DSP_SHIFT_ENA;
   logic [11:0] DSP_O;

   always #5 CLK = ~CLK;

   dsp12_sched #(.NREQ(2), .LEN_W(8), .TIMEOUT(255)) dut (
      .CLK(CLK), .RST_N(RST_N), .START(START), .LEN(LEN), .SHIFT(SHIFT),
      .GNT(GNT), .BUSY(BUSY), .OPND_VALID(OPND_VALID), .OPND_READY(OPND_READY),
      .OPND_A(OPND_A), .OPND_B(OPND_B), .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .RES_DATA(RES_DATA), .RES_ERR(RES_ERR), .DSP_A(DSP_A), .DSP_B(DSP_B),
      .DSP_C(DSP_C), .DSP_OP(DSP_OP), .DSP_CE(DSP_CE), .DSP_RST(DSP_RST),
      .DSP_SHIFT_ENA(DSP_SHIFT_ENA), .DSP_O(DSP_O)
   );

   // Behavioural DSP12 (signed MAC, W and O registers), starting from garbage
   logic signed [11:0] dsp_w  = 12'sh5A5;
   logic signed [11:0] dsp_o  = 12'sh3C3;
   logic [3:0]         dsp_sh = 4'd9;
   wire  signed [7:0]  dsp_prod = $signed(DSP_A) * $signed(DSP_B);
   assign DSP_O = dsp_o;

   always @(posedge CLK) begin
      if (DSP_RST) begin
         dsp_w  <= '0;
         dsp_o  <= '0;
         dsp_sh <= '0;
      end else begin
         if (DSP_SHIFT_ENA) dsp_sh <= DSP_C;
         if (DSP_CE) begin
            dsp_w <= dsp_w + dsp_prod;
            dsp_o <= dsp_w >>> dsp_sh;
         end
      end
   end

   int n_pass  = 0;
   int n_total = 0;
   int rr_ptr  = 0;
   int pa[0:15];
   int pb[0:15];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Expected result: 12-bit wrapped sum of products, then arithmetic shift
   function automatic logic [11:0] exp_res(input int n, input int sh);
      int s;
      s = 0;
      for (int i = 0; i < n; i++) s += pa[i] * pb[i];
      s = s & 'hFFF;
      if (s >= 2048) s -= 4096;
      s = s >>> sh;
      return 12'(s);
   endfunction

   function automatic int pick(input logic [1:0] req);
      int c;
      for (int i = 0; i < 2; i++) begin
         c = (rr_ptr + i) % 2;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   task automatic run_job(input logic [1:0] req, input int gap_pct, input int stop_after,
                          input int rdy_wait, input bit poke, input bit exp_err,
                          input string tag, output int lat, output bit rdy_seen,
                          output logic [1:0] g_obs);
      int win, n, sh, idx, cyc;
      bit got_gnt, vld, rdy;
      logic [1:0]  gexp;
      logic [11:0] exp_d;
      win = pick(req);
      n   = int'(LEN[win*8 +: 8]);
      sh  = int'(SHIFT[win*4 +: 4]);
      gexp = '0;
      gexp[win] = 1'b1;
      lat = -1; rdy_seen = 1'b0; g_obs = '0;
      idx = 0; cyc = 0; got_gnt = 1'b0;
      @(posedge CLK); #1;
      START = req;
      while (cyc < 400) begin
         vld = (stop_after >= 0 && idx >= stop_after) ? 1'b0 : ($urandom_range(99) >= gap_pct);
         OPND_VALID = vld;
         OPND_A = 4'(pa[idx % 16]);
         OPND_B = 4'(pb[idx % 16]);
         @(negedge CLK);
         rdy = OPND_READY;
         if (rdy) rdy_seen = 1'b1;
         @(posedge CLK); #1;
         cyc++;
         if (rdy && vld) idx++;
         if (!got_gnt && GNT != 2'b00) begin
            got_gnt = 1'b1;
            g_obs = GNT;
            check({tag, "_gnt"}, GNT, gexp);
            START = '0;
            rr_ptr = (win + 1) % 2;
         end
         if (RES_VALID) begin
            lat = cyc;
            break;
         end
      end
      OPND_VALID = 1'b0;
      START = '0;
      check({tag, "_gnt_seen"}, got_gnt, 1'b1);
      if (stop_after < 0) check({tag, "_res_seen"}, (lat >= 0), 1'b1);
      if (gap_pct == 0 && stop_after < 0) check({tag, "_lat"}, lat, n + 4);
      if (lat >= 0) begin
         exp_d = exp_err ? 12'h000 : exp_res(n, sh);
         check({tag, "_data"}, RES_DATA, exp_d);
         check({tag, "_err"}, RES_ERR, exp_err);
         for (int k = 0; k < rdy_wait; k++) begin
            if (poke) START = 2'b11;
            @(posedge CLK); #1;
            check({tag, "_hold"}, {RES_VALID, RES_DATA, GNT}, {1'b1, exp_d, gexp});
         end
         START = '0;
         RES_READY = 1'b1;
         @(posedge CLK); #1;
         RES_READY = 1'b0;
         check({tag, "_done"}, {BUSY, GNT, RES_VALID}, 4'b0000);
      end
   endtask

   task automatic do_reset();
      RST_N = 1'b0;
      #2;
      check("rst_outputs",
            {GNT, BUSY, OPND_READY, RES_VALID, RES_ERR, DSP_CE, DSP_SHIFT_ENA,
             DSP_A, DSP_B, DSP_C, DSP_OP}, 22'd0);
      rr_ptr = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   int          lat;
   bit          rs;
   logic [1:0]  g;
   logic [1:0]  gseq [3];

   initial begin
      START = '0; LEN = '0; SHIFT = '0; OPND_VALID = 1'b0;
      OPND_A = '0; OPND_B = '0; RES_READY = 1'b0;
      gseq[0] = 2'b01; gseq[1] = 2'b10; gseq[2] = 2'b01;
      foreach (pa[i]) begin pa[i] = 0; pb[i] = 0; end
      do_reset();

      // Three-pair job, unshifted
      LEN[7:0] = 8'd3; SHIFT[3:0] = 4'd0;
      pa[0] = 3;  pb[0] = 2;
      pa[1] = -1; pb[1] = 4;
      pa[2] = 7;  pb[2] = 7;
      run_job(2'b01, 0, -1, 0, 0, 1'b0, "mac3", lat, rs, g);

      // Most-negative operands with a shift
      LEN[7:0] = 8'd2; SHIFT[3:0] = 4'd3;
      pa[0] = -8; pb[0] = 7;
      pa[1] = -8; pb[1] = 7;
      run_job(2'b01, 0, -1, 0, 0, 1'b0, "neg", lat, rs, g);

      // Empty job: no operand handshake at all
      LEN[7:0] = 8'd0; SHIFT[3:0] = 4'd5;
      run_job(2'b01, 0, -1, 0, 0, 1'b0, "len0", lat, rs, g);
      check("len0_no_ready", rs, 1'b0);

      // Both requesters continuously, starting from a fresh pointer
      do_reset();
      LEN = {8'd1, 8'd1}; SHIFT = '0;
      for (int j = 0; j < 3; j++) begin
         pa[0] = int'($urandom_range(15)) - 8;
         pb[0] = int'($urandom_range(15)) - 8;
         run_job(2'b11, 0, -1, 0, 0, 1'b0, "rr", lat, rs, g);
         check("rr_seq", g, gseq[j]);
      end

      // Result stalled for 10 cycles with competing requests poked in
      LEN = {8'd2, 8'd2}; SHIFT = {4'd1, 4'd1};
      for (int i = 0; i < 2; i++) begin
         pa[i] = int'($urandom_range(15)) - 8;
         pb[i] = int'($urandom_range(15)) - 8;
      end
      run_job(2'b10, 0, -1, 10, 1, 1'b0, "stall", lat, rs, g);

      // Randomised jobs
      for (int j = 0; j < 25; j++) begin
         logic [1:0] req;
         req = 2'($urandom_range(3));
         if (req == 2'b00) req = 2'b01;
         LEN   = {8'($urandom_range(7)), 8'($urandom_range(7))};
         SHIFT = {4'($urandom_range(15)), 4'($urandom_range(15))};
         for (int i = 0; i < 16; i++) begin
            pa[i] = int'($urandom_range(15)) - 8;
            pb[i] = int'($urandom_range(15)) - 8;
         end
         run_job(req, int'($urandom_range(50)), -1, int'($urandom_range(3)), 0, 1'b0,
                 "rand", lat, rs, g);
      end

      // Operand source goes quiet after two of four beats
      LEN[7:0] = 8'd4; SHIFT[3:0] = 4'd0;
`ifdef DSP12_SCHED_TIMEOUT_EN
      run_job(2'b01, 0, 2, 0, 0, 1'b1, "tmo", lat, rs, g);
      check("tmo_lat", lat, 260);
`else
      run_job(2'b01, 0, 2, 0, 0, 1'b0, "stuck", lat, rs, g);
      check("stuck_no_result", lat, 32'hFFFF_FFFF);
`endif

      // Reset in the middle of a job, then a clean job afterwards
      @(posedge CLK); #1;
      LEN[15:8] = 8'd3;
      START = 2'b10;
      repeat (4) @(posedge CLK);
      #1;
      check("mid_busy", BUSY, 1'b1);
      START = '0;
      do_reset();
      LEN = {8'd3, 8'd3}; SHIFT = {4'd2, 4'd2};
      for (int i = 0; i < 3; i++) begin
         pa[i] = int'($urandom_range(15)) - 8;
         pb[i] = int'($urandom_range(15)) - 8;
      end
      run_job(2'b11, 0, -1, 0, 0, 1'b0, "post_rst", lat, rs, g);
      check("post_rst_gnt", g, 2'b01);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
